// File: rtl/irq_arbiter_if.sv
// Bus bundle between the interrupt sources/counter side and irq_arbiter.
// master drives requests, mask writes and the accept/EOI handshake; slave is the arbiter.
interface irq_arbiter_if;
    logic [6:0] src_req;
    logic       mask_wr;
    logic [6:0] mask_data;
    logic [6:0] pend_clr;
    logic       inter_i;
    logic       eoi_i;
    logic [2:0] irq_code;
    logic       busy;
    logic [2:0] act_code;
    logic [6:0] mask_q;
    logic [6:0] pend_q;

    modport master (
        output src_req, mask_wr, mask_data, pend_clr, inter_i, eoi_i,
        input  irq_code, busy, act_code, mask_q, pend_q
    );

    modport slave (
        input  src_req, mask_wr, mask_data, pend_clr, inter_i, eoi_i,
        output irq_code, busy, act_code, mask_q, pend_q
    );
endinterface

// File: rtl/irq_arbiter.sv
// Interrupt front-end: synchronises 7 request lines, latches edges, masks and priority-encodes them.
// Define IRQ_LEVEL_EN for level-sensitive pending (pend_q follows the synchronised lines).
//
// state   | meaning
// IDLE    | nothing offered; waits for an eligible pending source
// REQ     | irq_code offered to the counter, re-evaluated each cycle until accepted
// SERVICE | one interrupt in service; offers suppressed until eoi_i
module irq_arbiter #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MASK_RST    = 7'h7F
) (
    input logic           clk,
    input logic           rst,
    irq_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0][6:0] sync_q;
    logic [6:0] prev_q;
    logic [6:0] pend_q, pend_d;
    logic [6:0] mask_q;
    logic [6:0] sync_out;
    logic [6:0] edge_det;
    logic [6:0] elig;
    logic [6:0] accept_clr;
    logic [2:0] win_code;

    state_t     state_q, state_d;
    logic [2:0] irq_code_q, irq_code_d;
    logic [2:0] act_code_q, act_code_d;
    logic       busy_q, busy_d;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign edge_det = sync_out & ~prev_q;
    assign elig     = pend_q & mask_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= '0;
            pend_q <= '0;
            mask_q <= MASK_RST;
        end else begin
            sync_q[0] <= bus.src_req;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            prev_q <= sync_out;
            pend_q <= pend_d;
            if (bus.mask_wr) begin
                mask_q <= bus.mask_data;
            end
        end
    end

`ifdef IRQ_LEVEL_EN
    always_comb begin
        pend_d = sync_out;
    end
`else
    // A fresh edge outranks any clear landing in the same cycle.
    always_comb begin
        pend_d = (pend_q & ~bus.pend_clr & ~accept_clr) | edge_det;
    end
`endif

    // Ascending scan so the highest eligible bit is the last one written.
    always_comb begin
        win_code = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (elig[i]) begin
                win_code = 3'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            irq_code_q <= 3'd0;
            act_code_q <= 3'd0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            irq_code_q <= irq_code_d;
            act_code_q <= act_code_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        irq_code_d = irq_code_q;
        act_code_d = act_code_q;
        busy_d     = busy_q;
        accept_clr = 7'd0;
        unique case (state_q)
            IDLE: begin
                irq_code_d = win_code;
                if (win_code != 3'd0) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (win_code == 3'd0) begin
                    state_d    = IDLE;
                    irq_code_d = 3'd0;
                end else if (bus.inter_i) begin
                    // The counter accepted what it saw, i.e. the registered offer.
                    state_d    = SERVICE;
                    act_code_d = irq_code_q;
                    irq_code_d = 3'd0;
                    busy_d     = 1'b1;
                    for (int i = 0; i < 7; i++) begin
                        accept_clr[i] = (irq_code_q == 3'(i + 1));
                    end
                end else begin
                    irq_code_d = win_code;
                end
            end
            SERVICE: begin
                irq_code_d = 3'd0;
                if (bus.eoi_i) begin
                    state_d    = IDLE;
                    act_code_d = 3'd0;
                    busy_d     = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                irq_code_d = 3'd0;
                act_code_d = 3'd0;
                busy_d     = 1'b0;
            end
        endcase
    end

    assign bus.irq_code = irq_code_q;
    assign bus.act_code = act_code_q;
    assign bus.busy     = busy_q;
    assign bus.mask_q   = mask_q;
    assign bus.pend_q   = pend_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: stimulus pushes timed expectations, a negedge monitor pops and compares.
module tb_irq_arbiter;

    localparam int S_IRQ  = 0;
    localparam int S_BUSY = 1;
    localparam int S_ACT  = 2;
    localparam int S_MASK = 3;
    localparam int S_PEND = 4;

    typedef struct {
        int         at;
        int         sig;
        logic [7:0] val;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   edge_cnt = 0;
    int   n_vec = 0;
    int   n_fail = 0;
    exp_t sbq[$];

    irq_arbiter_if bus ();

    irq_arbiter #(.SYNC_STAGES(2), .MASK_RST(7'h7F)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic logic [7:0] actual(input int sig);
        case (sig)
            S_IRQ:   return {5'd0, bus.irq_code};
            S_BUSY:  return {7'd0, bus.busy};
            S_ACT:   return {5'd0, bus.act_code};
            S_MASK:  return {1'b0, bus.mask_q};
            default: return {1'b0, bus.pend_q};
        endcase
    endfunction

    task automatic expect_at(input int k, input int sig, input logic [7:0] val, input string name);
        exp_t e;
        e.at   = edge_cnt + k;
        e.sig  = sig;
        e.val  = val;
        e.name = name;
        sbq.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: checks every expectation due at the edge just completed.
    initial begin
        exp_t e;
        logic [7:0] a;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0 && sbq[0].at <= edge_cnt) begin
                e = sbq.pop_front();
                n_vec++;
                if (e.at < edge_cnt) begin
                    n_fail++;
                    $display("FAIL %s: expectation for edge %0d missed at edge %0d", e.name, e.at, edge_cnt);
                end else begin
                    a = actual(e.sig);
                    if (a !== e.val) begin
                        n_fail++;
                        $display("FAIL %s @edge %0d: got %h, expected %h", e.name, edge_cnt, a, e.val);
                    end
                end
            end
        end
    end

    initial begin
        bus.src_req   = 7'd0;
        bus.mask_wr   = 1'b0;
        bus.mask_data = 7'd0;
        bus.pend_clr  = 7'd0;
        bus.inter_i   = 1'b0;
        bus.eoi_i     = 1'b0;

        // reset state
        tick(2);
        expect_at(0, S_IRQ, 8'h00, "rst_irq");
        expect_at(0, S_BUSY, 8'h00, "rst_busy");
        expect_at(0, S_ACT, 8'h00, "rst_act");
        expect_at(0, S_MASK, 8'h7F, "rst_mask");
        expect_at(0, S_PEND, 8'h00, "rst_pend");
        rst = 1'b0;
        tick(1);

        // single request on bit 2
        bus.src_req = 7'h04;
        expect_at(2, S_PEND, 8'h00, "t1_pend_early");
        expect_at(3, S_PEND, 8'h04, "t1_pend_set");
        expect_at(3, S_IRQ, 8'h00, "t1_irq_early");
        expect_at(4, S_IRQ, 8'h03, "t1_irq_offer");
        tick(4);
        bus.inter_i = 1'b1;
        expect_at(1, S_IRQ, 8'h00, "t1_irq_acc");
        expect_at(1, S_ACT, 8'h03, "t1_act");
        expect_at(1, S_BUSY, 8'h01, "t1_busy");
        expect_at(1, S_PEND, 8'h00, "t1_pend_clr");
        tick(1);
        bus.inter_i = 1'b0;
        bus.src_req = 7'h00;
        tick(2);
        bus.eoi_i = 1'b1;
        expect_at(1, S_BUSY, 8'h00, "t1_eoi_busy");
        expect_at(1, S_ACT, 8'h00, "t1_eoi_act");
        expect_at(2, S_IRQ, 8'h00, "t1_no_reoffer");
        tick(1);
        bus.eoi_i = 1'b0;
        tick(3);

        // priority preemption: bit0 then bit5
        bus.src_req = 7'h01;
        expect_at(4, S_IRQ, 8'h01, "t2_offer1");
        tick(6);
        bus.src_req = 7'h21;
        expect_at(3, S_IRQ, 8'h01, "t2_still1");
        expect_at(3, S_PEND, 8'h21, "t2_pend21");
        expect_at(4, S_IRQ, 8'h06, "t2_preempt6");
        tick(4);
        bus.inter_i = 1'b1;
        expect_at(1, S_ACT, 8'h06, "t2_act6");
        expect_at(1, S_PEND, 8'h01, "t2_pend01");
        expect_at(1, S_IRQ, 8'h00, "t2_irq_svc");
        expect_at(1, S_BUSY, 8'h01, "t2_busy");
        tick(1);
        bus.inter_i = 1'b0;
        tick(1);
        bus.eoi_i = 1'b1;
        expect_at(1, S_BUSY, 8'h00, "t2_eoi_busy");
        expect_at(1, S_IRQ, 8'h00, "t2_eoi_irq");
        expect_at(2, S_IRQ, 8'h01, "t2_reoffer1");
        tick(1);
        bus.eoi_i = 1'b0;
        tick(1);
        bus.inter_i = 1'b1;
        expect_at(1, S_ACT, 8'h01, "t2_act1");
        expect_at(1, S_PEND, 8'h00, "t2_pend_empty");
        tick(1);
        bus.inter_i = 1'b0;
        bus.eoi_i = 1'b1;
        expect_at(1, S_BUSY, 8'h00, "t2_eoi2_busy");
        expect_at(1, S_ACT, 8'h00, "t2_eoi2_act");
        tick(1);
        bus.eoi_i = 1'b0;
        bus.src_req = 7'h00;
        tick(2);

        // masking
        bus.mask_wr = 1'b1;
        bus.mask_data = 7'h7E;
        expect_at(1, S_MASK, 8'h7E, "t3_mask7e");
        tick(1);
        bus.mask_wr = 1'b0;
        bus.src_req = 7'h01;
        expect_at(3, S_PEND, 8'h01, "t3_pend_masked");
        expect_at(4, S_IRQ, 8'h00, "t3_irq_masked_a");
        expect_at(5, S_IRQ, 8'h00, "t3_irq_masked_b");
        tick(1);
        bus.src_req = 7'h00;
        tick(5);
        bus.mask_wr = 1'b1;
        bus.mask_data = 7'h7F;
        expect_at(1, S_MASK, 8'h7F, "t3_mask7f");
        expect_at(1, S_IRQ, 8'h00, "t3_irq_unmask_early");
        expect_at(2, S_IRQ, 8'h01, "t3_irq_unmasked");
        tick(1);
        bus.mask_wr = 1'b0;
        tick(1);

        // withdrawal via pend_clr
        bus.pend_clr = 7'h01;
        expect_at(1, S_PEND, 8'h00, "t4_clr1_pend");
        expect_at(1, S_IRQ, 8'h01, "t4_clr1_irq_lag");
        expect_at(2, S_IRQ, 8'h00, "t4_clr1_withdrawn");
        tick(1);
        bus.pend_clr = 7'h00;
        tick(1);
        bus.src_req = 7'h02;
        expect_at(3, S_PEND, 8'h02, "t4_pend02");
        expect_at(4, S_IRQ, 8'h02, "t4_offer2");
        tick(4);
        bus.pend_clr = 7'h02;
        expect_at(1, S_PEND, 8'h00, "t4_clr2_pend");
        expect_at(2, S_IRQ, 8'h00, "t4_clr2_withdrawn");
        tick(1);
        bus.pend_clr = 7'h00;
        tick(1);
        bus.inter_i = 1'b1;
        expect_at(1, S_BUSY, 8'h00, "t4_inter_idle_busy");
        expect_at(1, S_ACT, 8'h00, "t4_inter_idle_act");
        expect_at(1, S_IRQ, 8'h00, "t4_inter_idle_irq");
        tick(1);
        bus.inter_i = 1'b0;

        // eoi while idle, then edge coinciding with pend_clr
        bus.eoi_i = 1'b1;
        expect_at(1, S_BUSY, 8'h00, "t5_eoi_idle_busy");
        expect_at(1, S_IRQ, 8'h00, "t5_eoi_idle_irq");
        expect_at(1, S_PEND, 8'h00, "t5_eoi_idle_pend");
        expect_at(1, S_ACT, 8'h00, "t5_eoi_idle_act");
        tick(1);
        bus.eoi_i = 1'b0;
        bus.src_req = 7'h00;
        tick(3);
        bus.src_req = 7'h02;
        tick(2);
        bus.pend_clr = 7'h02;
        expect_at(1, S_PEND, 8'h02, "t5_set_beats_clr");
        tick(1);
        bus.pend_clr = 7'h00;
        expect_at(1, S_IRQ, 8'h02, "t5_offer2");
        tick(1);

        // async reset during service with pending 0x12
        bus.inter_i = 1'b1;
        expect_at(1, S_ACT, 8'h02, "t6_act2");
        expect_at(1, S_BUSY, 8'h01, "t6_busy");
        tick(1);
        bus.inter_i = 1'b0;
        bus.src_req = 7'h00;
        bus.mask_wr = 1'b1;
        bus.mask_data = 7'h3F;
        expect_at(1, S_MASK, 8'h3F, "t6_mask3f");
        tick(1);
        bus.mask_wr = 1'b0;
        tick(2);
        bus.src_req = 7'h12;
        expect_at(3, S_PEND, 8'h12, "t6_pend12");
        expect_at(3, S_BUSY, 8'h01, "t6_busy_hold");
        expect_at(3, S_IRQ, 8'h00, "t6_no_nest");
        expect_at(3, S_ACT, 8'h02, "t6_act_hold");
        tick(4);
        rst = 1'b1;
        expect_at(0, S_IRQ, 8'h00, "t6_rst_irq");
        expect_at(0, S_BUSY, 8'h00, "t6_rst_busy");
        expect_at(0, S_ACT, 8'h00, "t6_rst_act");
        expect_at(0, S_MASK, 8'h7F, "t6_rst_mask");
        expect_at(0, S_PEND, 8'h00, "t6_rst_pend");
        tick(2);
        bus.src_req = 7'h00;
        rst = 1'b0;
        tick(3);
        expect_at(0, S_PEND, 8'h00, "t6_post_pend");
        expect_at(0, S_IRQ, 8'h00, "t6_post_irq");

        for (int i = 0; i < 20 && sbq.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sbq.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Interrupt front-end sitting directly upstream of the program-counter/call-stack stage.
- Synchronises up to 7 peripheral request lines and latches rising edges as pending.
- Applies an enable mask and priority-encodes the winner onto the 3-bit interrupt code consumed by the counter (irq3,irq2,irq1).
- Tracks the accept / end-of-interrupt handshake so exactly one interrupt is offered and serviced at a time.

Parameters:
- SYNC_STAGES, 2, number of flip-flop stages on each src_req line (min 2).
- MASK_RST, 7'h7F, reset value of enable mask (1 = source enabled).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- src_req  in  7  asynchronous peripheral requests; bit i maps to irq code i+1.
- mask_wr  in  1  write strobe for enable mask.
- mask_data  in  7  new enable mask, captured when mask_wr=1.
- pend_clr  in  7  write-one-to-clear pending bits (single-cycle).
- inter_i  in  1  counter reports interrupt accepted / in service.
- eoi_i  in  1  end-of-interrupt pulse from counter (RET 0 in service).
- irq_code  out  3  code offered to counter; 0 = none; bit2..0 drive irq3..irq1.
- busy  out  1  1 while in SERVICE state.
- act_code  out  3  code currently in service; 0 when idle.
- mask_q  out  7  current enable mask.
- pend_q  out  7  current pending register.

Behaviour:
- Reset (async): sync chains=0, prev-level=0, pend_q=0, mask_q=MASK_RST, state=IDLE, irq_code=0, act_code=0, busy=0.
- Sync: each src_req bit passes SYNC_STAGES flops; edge = sync_out & ~prev_level; prev_level registered each cycle.
- Pending update per bit, each cycle: next = (pend & ~pend_clr & ~accept_clr) | edge. A set by a new edge wins over any clear in the same cycle.
- Pending latched regardless of mask; mask gates only arbitration. elig = pend_q & mask_q.
- Priority: highest set bit of elig wins (bit6 -> code 7 highest, bit0 -> code 1 lowest). win_code = index+1, 0 if elig=0.
- mask_wr takes effect on the next edge; mask_q and mask_data are registered.
- All outputs are registered.
- FSM:
  - IDLE: irq_code=0. If win_code!=0 -> REQ, irq_code<=win_code.
  - REQ: irq_code is re-evaluated every cycle to the current win_code, so a higher-priority arrival preempts the offer before acceptance.
    - If win_code becomes 0 (masked/cleared) -> IDLE, irq_code<=0.
    - If inter_i=1 -> SERVICE: act_code<=irq_code, clear pending bit (irq_code-1) via accept_clr, irq_code<=0, busy<=1.
  - SERVICE: irq_code held 0 (no nesting); pending keeps collecting.
    - On eoi_i=1 -> IDLE: act_code<=0, busy<=0. New offer appears no earlier than the following cycle.
  - eoi_i outside SERVICE is ignored. inter_i in IDLE is ignored.
- Latency: if src_req is first sampled high at edge N, then pend_q bit sets at edge N+SYNC_STAGES and irq_code is nonzero after edge N+SYNC_STAGES+1.
- A request held high produces one pending set only; re-arming requires low then high.
- Reset mid-service: all state returns to reset values immediately; pending requests are lost.

Optional Feature:
- Macro IRQ_LEVEL_EN.
- Defined: level-sensitive mode. pend_q = sync_out each cycle; pend_clr and accept_clr have no effect. Source is re-offered after EOI if still asserted.
- Undefined: edge-latched behaviour as above.

Test Plan:
- Single request: mask=7F, src_req[2] 0->1 at edge N (SYNC_STAGES=2) -> pend_q=04 after N+2, irq_code=3 after N+3; inter_i=1 -> irq_code=0, act_code=3, busy=1, pend_q=00; eoi_i pulse -> busy=0, act_code=0.
- Priority/preempt: src_req[0] rises, irq_code=1 offered; two cycles later src_req[5] rises -> irq_code becomes 6 before inter_i; accept -> act_code=6, pend_q=01; after eoi_i -> irq_code=1 offered.
- Masking: mask_wr with mask_data=7E, then src_req[0] pulses -> pend_q=01, irq_code stays 0; write mask 7F -> irq_code=1 two cycles after mask_wr.
- Withdrawal: irq_code=2 in REQ, pend_clr=02 with no new edge -> pend_q=00, irq_code=0, state IDLE; inter_i ignored afterwards.
- Simultaneous: new edge on bit 1 in same cycle as pend_clr=02 -> pend_q bit1 remains 1; eoi_i while IDLE -> no change.
- Async reset asserted in SERVICE with pend_q=0x12 -> all outputs 0, mask_q=7F immediately, before the next clock edge.
